// File: rtl/quickq_pkg.sv
// -----------------------------------------------------------------------------
// quickq_pkg
// Shared types and helpers for the QuickQ sorted priority-queue engine.
//   pq_state_t : engine state (IDLE, ENQ_WALK, DEQ_SHIFT)
//   pq_before  : strict unsigned ordering test; true when key a must sit
//                closer to the head than key b
// -----------------------------------------------------------------------------
package quickq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ENQ_WALK  = 2'd1,
        DEQ_SHIFT = 2'd2
    } pq_state_t;

    // Widest key the ordering helper accepts; narrower keys are zero-extended
    // by the caller, which leaves an unsigned comparison unchanged.
    localparam int PQ_KEY_MAX_W = 256;

    function automatic logic pq_before(input logic [PQ_KEY_MAX_W-1:0] a,
                                       input logic [PQ_KEY_MAX_W-1:0] b,
                                       input logic                    max_first);
        return max_first ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/pq_sorted_queue_if.sv
// -----------------------------------------------------------------------------
// pq_sorted_queue_if
// Handshake bundle between a requester (master) and the sorted queue (slave).
//   enq_valid/enq_data/enq_ready : insert handshake
//   deq_req/deq_ready            : remove handshake
//   deq_valid/deq_data           : one-cycle result of a remove
//   count/full/empty             : occupancy status
//   busy/done                    : operation in progress / final-cycle pulse
// -----------------------------------------------------------------------------
interface pq_sorted_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              enq_valid;
    logic [DATA_W-1:0] enq_data;
    logic              enq_ready;
    logic              deq_req;
    logic              deq_ready;
    logic              deq_valid;
    logic [DATA_W-1:0] deq_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              busy;
    logic              done;

    modport master (
        output enq_valid, enq_data, deq_req,
        input  enq_ready, deq_ready, deq_valid, deq_data,
               count, full, empty, busy, done
    );

    modport slave (
        input  enq_valid, enq_data, deq_req,
        output enq_ready, deq_ready, deq_valid, deq_data,
               count, full, empty, busy, done
    );

endinterface

// File: rtl/pq_cmp_swap.sv
// -----------------------------------------------------------------------------
// pq_cmp_swap
// Combinational compare-and-swap cell used at the insert walk pointer.
//   carry     in  : key currently being carried down the array
//   stored    in  : key held at the walk pointer
//   write_key out : key to write back at the walk pointer
//   new_carry out : key to carry onward
//   swap      out : carry belongs before stored, so the two trade places
// -----------------------------------------------------------------------------
module pq_cmp_swap
    import quickq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit MAX_FIRST = 1'b1
) (
    input  logic [DATA_W-1:0] carry,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] write_key,
    output logic [DATA_W-1:0] new_carry,
    output logic              swap
);

    // Strict comparison: an equal key is passed over, so equal keys keep
    // their arrival order.
    assign swap      = pq_before(PQ_KEY_MAX_W'(carry), PQ_KEY_MAX_W'(stored), MAX_FIRST);
    assign write_key = swap ? carry  : stored;
    assign new_carry = swap ? stored : carry;

endmodule

// File: rtl/pq_sorted_queue.sv
// -----------------------------------------------------------------------------
// pq_sorted_queue
// Sorted priority queue holding up to DEPTH keys in a register array with the
// head at address 0. Inserts walk the array one address per cycle with
// compare-and-swap; removes return the head and shift the rest down.
//   clk  in : system clock
//   rst  in : synchronous active-high reset
//   bus     : pq_sorted_queue_if.slave handshake/status bundle
// -----------------------------------------------------------------------------
module pq_sorted_queue
    import quickq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter bit MAX_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    pq_sorted_queue_if.slave    bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    pq_state_t         state;
    pq_state_t         state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] carry;
    logic [CNT_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;

    logic              deq_valid_q;
    logic              deq_done_q;
    logic [DATA_W-1:0] deq_data_q;

    logic              full;
    logic              empty;
    logic              idle;
    logic              enq_fire;
    logic              deq_fire;
    logic              walk_last;
    logic              shift_last;

    logic [DATA_W-1:0] write_key;
    logic [DATA_W-1:0] new_carry;
    logic              swap;

    assign idx      = ptr[IDX_W-1:0];
    assign idx_next = idx + IDX_W'(1);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign idle  = (state == IDLE);

    // A pending dequeue blocks enqueue so the two never start together.
    assign bus.deq_ready = idle && !empty;
    assign bus.enq_ready = idle && !full && !(bus.deq_req && !empty);
    assign deq_fire      = bus.deq_req && bus.deq_ready;
    assign enq_fire      = bus.enq_valid && bus.enq_ready;

    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.busy      = !idle;
    assign bus.deq_valid = deq_valid_q;
    assign bus.deq_data  = deq_data_q;
    // A single-entry dequeue never leaves IDLE, so its done comes from a flop.
    assign bus.done      = walk_last || shift_last || deq_done_q;

    pq_cmp_swap #(
        .DATA_W    (DATA_W),
        .MAX_FIRST (MAX_FIRST)
    ) u_cmp_swap (
        .carry     (carry),
        .stored    (mem[idx]),
        .write_key (write_key),
        .new_carry (new_carry),
        .swap      (swap)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // In DEQ_SHIFT, count has already been decremented, so the last shift
    // is at ptr == count - 1.
    always_comb begin
        state_next = state;
        walk_last  = 1'b0;
        shift_last = 1'b0;
        case (state)
            IDLE: begin
                if (deq_fire) begin
                    if (count != CNT_W'(1)) state_next = DEQ_SHIFT;
                end else if (enq_fire) begin
                    state_next = ENQ_WALK;
                end
            end
            ENQ_WALK: begin
                walk_last = (ptr == count);
                if (walk_last) state_next = IDLE;
            end
            DEQ_SHIFT: begin
                shift_last = (ptr == count - CNT_W'(1));
                if (shift_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            ptr         <= '0;
            carry       <= '0;
            deq_valid_q <= 1'b0;
            deq_done_q  <= 1'b0;
            deq_data_q  <= '0;
        end else begin
            deq_valid_q <= 1'b0;
            deq_done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (deq_fire) begin
                        deq_data_q  <= mem[0];
                        deq_valid_q <= 1'b1;
                        deq_done_q  <= (count == CNT_W'(1));
                        count       <= count - CNT_W'(1);
                        ptr         <= '0;
                    end else if (enq_fire) begin
                        carry <= bus.enq_data;
                        ptr   <= '0;
                    end
                end
                ENQ_WALK: begin
                    if (walk_last) begin
                        count <= count + CNT_W'(1);
                    end else begin
                        carry <= new_carry;
                        ptr   <= ptr + CNT_W'(1);
                    end
                end
                DEQ_SHIFT: begin
                    ptr <= ptr + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Key storage carries no reset; entries at or above count are don't-care.
    // Writes are suppressed during reset so an aborted walk leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state)
                ENQ_WALK: begin
                    if (walk_last)  mem[idx] <= carry;
                    else if (swap)  mem[idx] <= write_key;
                end
                DEQ_SHIFT: mem[idx] <= mem[idx_next];
                default: ;
            endcase
        end
    end

endmodule
